ysyx_22050710_if_stage: RTL

- IF stage control and datapath. Sits between the PC/inst-SRAM request logic and the ID stage.
- Drives the PC load enable, which doubles as the inst SRAM read enable, and captures SRAM read data that arrives one cycle after a request.
- Holds the fetched instruction in a one-entry buffer while ID stalls, and presents {pc, inst} to ID under a valid/allowin handshake.
- Squashes the wrong-path instruction when ID resolves a taken branch.

---
 rtl/ysyx_22050710_if_stage.sv | 110 +++++++++++
 1 files changed

// File: rtl/ysyx_22050710_if_stage.sv
//==============================================================================
// Module      : ysyx_22050710_if_stage
// Description : Instruction-fetch stage control and datapath. Sits between the
//               PC / instruction-SRAM request logic and the ID stage.
//               - o_pc_load updates the PC and also acts as the SRAM read
//                 enable. Read data returns one cycle after a load.
//               - A one-entry buffer holds the fetched instruction while ID
//                 stalls, because SRAM output is only trusted for one cycle.
//               - {pc, inst} is handed to ID under a valid/allowin handshake.
//               - A taken branch resolved in ID squashes the instruction
//                 currently in IF, which is the fall-through of the branch.
// Ports       :
//   i_clk              clock
//   i_rst              asynchronous active-high reset
//   i_pc               PC register (address of the data on i_inst_sram_rdata)
//   i_inst_sram_rdata  SRAM read data, valid one cycle after a load
//   i_br_taken         ID has a resolved branch this cycle
//   i_br_sel           branch target selected (taken)
//   i_id_allowin       ID can accept an instruction this cycle
//   o_pc_load          PC update enable / SRAM read enable
//   o_if_to_id_valid   IF presents a valid instruction to ID
//   o_if_to_id_bus     {pc, inst}, pc in the MSBs
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ysyx_22050710_if_stage #(
    parameter int PC_WD       = 64,
    parameter int INST_WD     = 32,
    parameter int IF_TO_ID_WD = PC_WD + INST_WD
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [PC_WD-1:0]       i_pc,
    input  logic [INST_WD-1:0]     i_inst_sram_rdata,
    input  logic                   i_br_taken,
    input  logic                   i_br_sel,
    input  logic                   i_id_allowin,
    output logic                   o_pc_load,
    output logic                   o_if_to_id_valid,
    output logic [IF_TO_ID_WD-1:0] o_if_to_id_bus
);

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    logic               r_if_valid;     // IF holds a fetched, unconsumed instruction
    logic               r_rdata_fresh;  // a load happened last cycle; SRAM data is current
    logic               r_buf_valid;    // r_buf_inst holds the instruction
    logic [INST_WD-1:0] r_buf_inst;

    //--------------------------------------------------------------------------
    // Combinational control
    //--------------------------------------------------------------------------
    logic               w_ready_go;
    logic               w_if_allowin;
    logic               w_flush;
    logic [INST_WD-1:0] w_inst;
    logic               w_capture;

    // The instruction SRAM answers in a single cycle, so IF never waits.
    assign w_ready_go   = 1'b1;
    assign w_if_allowin = !r_if_valid || (w_ready_go && i_id_allowin);
    assign w_flush      = i_br_taken && i_br_sel;

    // Outputs are forced low during reset so an asynchronous assertion in the
    // middle of a cycle cannot leave a stale request or valid on the wires.
    assign o_pc_load        = !i_rst && w_if_allowin;
    assign o_if_to_id_valid = !i_rst && r_if_valid && w_ready_go && !w_flush;

    // Once ID has stalled past the first data cycle the SRAM output may have
    // moved on, so the buffered copy takes priority.
    assign w_inst         = r_buf_valid ? r_buf_inst : i_inst_sram_rdata;
    assign o_if_to_id_bus = i_rst ? '0 : {i_pc, w_inst};

    // Capture the SRAM data on the first cycle it is valid if ID did not take
    // it (no load means ID stalled) and no flush is discarding it.
    assign w_capture = r_rdata_fresh && r_if_valid && !r_buf_valid;

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_if_valid    <= 1'b0;
            r_rdata_fresh <= 1'b0;
            r_buf_valid   <= 1'b0;
            r_buf_inst    <= '0;
        end else begin
            r_rdata_fresh <= o_pc_load;
            if (o_pc_load) begin
                // A new request always yields data next cycle. When this
                // coincides with a flush the PC loads the branch target, and
                // the squashed instruction is simply overwritten.
                r_if_valid  <= 1'b1;
                r_buf_valid <= 1'b0;
            end else if (w_flush) begin
                r_if_valid  <= 1'b0;
                r_buf_valid <= 1'b0;
            end else if (w_capture) begin
                r_buf_valid <= 1'b1;
                r_buf_inst  <= i_inst_sram_rdata;
            end
        end
    end

endmodule

`default_nettype wire
